// File: rtl/x_ramb_dp_param.sv
// x_ramb_dp_param
//   Parameterised true dual-port block RAM with a single clock. Both ports
//   address the same MEM_BITS-bit array at their own word widths. Each port
//   has a selectable write mode, a synchronous set/reset of its output, and
//   an optional second output register. Overlapping same-cycle accesses
//   raise a one-cycle COLL pulse and advance a saturating 8-bit counter.
//
// Ports
//   CLK            rising-edge clock shared by both ports
//   RST            synchronous active-high reset (outputs/counter only;
//                  the array contents are kept)
//   ENA/WEA/SSRA   port A enable, write enable, output set/reset
//   ADDRA, DIA     port A word address and write data
//   DOA            port A read data (1 or 2 edges latency, see DOA_REG)
//   ENB..DOB       port B equivalents
//   COLL           high for one cycle after a collision cycle
//   COLL_CNT       number of collision cycles, saturating at 255
module x_ramb_dp_param #(
  parameter int                 MEM_BITS     = 16384,
  parameter int                 WIDTH_A      = 2,
  parameter int                 WIDTH_B      = 4,
  parameter string              WRITE_MODE_A = "WRITE_FIRST",
  parameter string              WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [WIDTH_A-1:0] INIT_A       = '0,
  parameter logic [WIDTH_B-1:0] INIT_B       = '0,
  parameter logic [WIDTH_A-1:0] SRVAL_A      = '0,
  parameter logic [WIDTH_B-1:0] SRVAL_B      = '0,
  parameter int                 DOA_REG      = 0,
  parameter int                 DOB_REG      = 0,
  localparam int                AW_A         = $clog2(MEM_BITS / WIDTH_A),
  localparam int                AW_B         = $clog2(MEM_BITS / WIDTH_B)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ENA,
  input  logic               WEA,
  input  logic               SSRA,
  input  logic [AW_A-1:0]    ADDRA,
  input  logic [WIDTH_A-1:0] DIA,
  output logic [WIDTH_A-1:0] DOA,
  input  logic               ENB,
  input  logic               WEB,
  input  logic               SSRB,
  input  logic [AW_B-1:0]    ADDRB,
  input  logic [WIDTH_B-1:0] DIB,
  output logic [WIDTH_B-1:0] DOB,
  output logic               COLL,
  output logic [7:0]         COLL_CNT
);

  localparam int IW = $clog2(MEM_BITS);
  localparam int BW = IW + 1;
  localparam int LA = $clog2(WIDTH_A);
  localparam int LB = $clog2(WIDTH_B);

  typedef enum logic [1:0] {
    WRITE_FIRST_M,
    READ_FIRST_M,
    NO_CHANGE_M
  } wmode_t;

  localparam wmode_t MODE_A = (WRITE_MODE_A == "READ_FIRST") ? READ_FIRST_M :
                              (WRITE_MODE_A == "NO_CHANGE")  ? NO_CHANGE_M  :
                                                               WRITE_FIRST_M;
  localparam wmode_t MODE_B = (WRITE_MODE_B == "READ_FIRST") ? READ_FIRST_M :
                              (WRITE_MODE_B == "NO_CHANGE")  ? NO_CHANGE_M  :
                                                               WRITE_FIRST_M;

  // Flat bit array; each port views it at its own word width.
  logic [MEM_BITS-1:0] mem = '0;

  // Lowest array bit of each addressed word.
  logic [IW-1:0] base_a;
  logic [IW-1:0] base_b;
  assign base_a = IW'(ADDRA) << LA;
  assign base_b = IW'(ADDRB) << LB;

  logic [WIDTH_A-1:0] word_a;
  logic [WIDTH_B-1:0] word_b;
  assign word_a = mem[base_a +: WIDTH_A];
  assign word_b = mem[base_b +: WIDTH_B];

  // Bit-range overlap test, one bit wider so the exclusive end never wraps.
  logic [BW-1:0] lo_a, lo_b, end_a, end_b;
  logic          overlap;
  logic          coll_now;
  assign lo_a     = {1'b0, base_a};
  assign lo_b     = {1'b0, base_b};
  assign end_a    = lo_a + BW'(WIDTH_A);
  assign end_b    = lo_b + BW'(WIDTH_B);
  assign overlap  = (lo_a < end_b) && (lo_b < end_a);
  assign coll_now = ENA && ENB && (WEA || WEB) && overlap;

  // Array writes. Port B is assigned after port A, so on a write-write
  // collision the overlapping bits take port B data while the remaining
  // bits of both words are written normally.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (ENA && WEA) mem[base_a +: WIDTH_A] <= DIA;
      if (ENB && WEB) mem[base_b +: WIDTH_B] <= DIB;
    end
  end

  // Read stages. Reads see the array before this edge's writes, which
  // gives pre-write data to the reading side of a read-write collision.
  logic [WIDTH_A-1:0] stage_a, out_a, nxt_a;
  logic [WIDTH_B-1:0] stage_b, out_b, nxt_b;

  // With an output register, SSR acts on that register only, so stage 1
  // ignores it; without one, stage 1 is the output and applies SSR itself.
  always_comb begin
    nxt_a = stage_a;
    if (SSRA && (DOA_REG == 0)) begin
      nxt_a = SRVAL_A;
    end else if (!WEA) begin
      nxt_a = word_a;
    end else begin
      case (MODE_A)
        WRITE_FIRST_M: nxt_a = DIA;
        READ_FIRST_M:  nxt_a = word_a;
        default:       nxt_a = stage_a;
      endcase
    end
  end

  always_comb begin
    nxt_b = stage_b;
    if (SSRB && (DOB_REG == 0)) begin
      nxt_b = SRVAL_B;
    end else if (!WEB) begin
      nxt_b = word_b;
    end else begin
      case (MODE_B)
        WRITE_FIRST_M: nxt_b = DIB;
        READ_FIRST_M:  nxt_b = word_b;
        default:       nxt_b = stage_b;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_a <= INIT_A;
      out_a   <= INIT_A;
    end else if (ENA) begin
      stage_a <= nxt_a;
      out_a   <= SSRA ? SRVAL_A : stage_a;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_b <= INIT_B;
      out_b   <= INIT_B;
    end else if (ENB) begin
      stage_b <= nxt_b;
      out_b   <= SSRB ? SRVAL_B : stage_b;
    end
  end

  assign DOA = (DOA_REG != 0) ? out_a : stage_a;
  assign DOB = (DOB_REG != 0) ? out_b : stage_b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      COLL     <= 1'b0;
      COLL_CNT <= '0;
    end else begin
      COLL <= coll_now;
      if (coll_now && (COLL_CNT != 8'hFF)) COLL_CNT <= COLL_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_x_ramb_dp_param.sv
// Directed bench for x_ramb_dp_param. Four instances share one stimulus:
// WRITE_FIRST, READ_FIRST and NO_CHANGE without output registers, plus a
// WRITE_FIRST instance with both output registers enabled.
module tb_x_ramb_dp_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena, wea, ssra;
  logic [12:0] addra;
  logic [1:0]  dia;
  logic        enb, web, ssrb;
  logic [11:0] addrb;
  logic [3:0]  dib;

  logic [1:0] doa_wf, doa_rf, doa_nc, doa_rg;
  logic [3:0] dob_wf, dob_rf, dob_nc, dob_rg;
  logic       coll_wf, coll_rf, coll_nc, coll_rg;
  logic [7:0] cnt_wf, cnt_rf, cnt_nc, cnt_rg;

  int unsigned n_tot = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  x_ramb_dp_param #(
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
    .INIT_A(2'b10), .INIT_B(4'hC), .SRVAL_A(2'b01), .SRVAL_B(4'hA),
    .DOA_REG(0), .DOB_REG(0)
  ) u_wf (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .SSRA(ssra), .ADDRA(addra), .DIA(dia), .DOA(doa_wf),
    .ENB(enb), .WEB(web), .SSRB(ssrb), .ADDRB(addrb), .DIB(dib), .DOB(dob_wf),
    .COLL(coll_wf), .COLL_CNT(cnt_wf)
  );

  x_ramb_dp_param #(
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .INIT_A(2'b10), .INIT_B(4'hC), .SRVAL_A(2'b01), .SRVAL_B(4'hA),
    .DOA_REG(0), .DOB_REG(0)
  ) u_rf (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .SSRA(ssra), .ADDRA(addra), .DIA(dia), .DOA(doa_rf),
    .ENB(enb), .WEB(web), .SSRB(ssrb), .ADDRB(addrb), .DIB(dib), .DOB(dob_rf),
    .COLL(coll_rf), .COLL_CNT(cnt_rf)
  );

  x_ramb_dp_param #(
    .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("NO_CHANGE"),
    .INIT_A(2'b10), .INIT_B(4'hC), .SRVAL_A(2'b01), .SRVAL_B(4'hA),
    .DOA_REG(0), .DOB_REG(0)
  ) u_nc (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .SSRA(ssra), .ADDRA(addra), .DIA(dia), .DOA(doa_nc),
    .ENB(enb), .WEB(web), .SSRB(ssrb), .ADDRB(addrb), .DIB(dib), .DOB(dob_nc),
    .COLL(coll_nc), .COLL_CNT(cnt_nc)
  );

  x_ramb_dp_param #(
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
    .INIT_A(2'b10), .INIT_B(4'hC), .SRVAL_A(2'b01), .SRVAL_B(4'hA),
    .DOA_REG(1), .DOB_REG(1)
  ) u_rg (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .SSRA(ssra), .ADDRA(addra), .DIA(dia), .DOA(doa_rg),
    .ENB(enb), .WEB(web), .SSRB(ssrb), .ADDRB(addrb), .DIB(dib), .DOB(dob_rg),
    .COLL(coll_rg), .COLL_CNT(cnt_rg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic en, input logic we, input logic ssr,
                       input logic [12:0] addr, input logic [1:0] di);
    ena = en; wea = we; ssra = ssr; addra = addr; dia = di;
  endtask

  task automatic set_b(input logic en, input logic we, input logic ssr,
                       input logic [11:0] addr, input logic [3:0] di);
    enb = en; web = we; ssrb = ssr; addrb = addr; dib = di;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    tick;
    check("rst_doa",  doa_wf, 2'b10);
    check("rst_dob",  dob_wf, 4'hC);
    check("rst_coll", coll_wf, 0);
    check("rst_cnt",  cnt_wf, 0);
    check("rst_doa_rg", doa_rg, 2'b10);
    check("rst_dob_rg", dob_rg, 4'hC);
    rst = 1'b0;

    // Port A writes words 0 and 1; port-A write-mode behaviour
    set_a(1, 1, 0, 0, 2'b01);
    tick;
    check("wa0_wf", doa_wf, 2'b01);
    check("wa0_rf", doa_rf, 2'b00);
    check("wa0_nc", doa_nc, 2'b10);
    check("wa0_rg", doa_rg, 2'b10);
    set_a(1, 1, 0, 1, 2'b10);
    tick;
    check("wa1_wf", doa_wf, 2'b10);
    check("wa1_rg", doa_rg, 2'b01);

    // Port B read of word 0 spans A words 0 and 1
    set_a(0, 0, 0, 0, 0);
    set_b(1, 0, 0, 0, 0);
    tick;
    check("rb0_wf", dob_wf, 4'b1001);
    check("rb0_rg_lat", dob_rg, 4'hC);
    check("rb0_coll", coll_wf, 0);
    check("ena0_freeze_rg", doa_rg, 2'b01);
    tick;
    check("rb0_rg", dob_rg, 4'b1001);

    // B writes word 1 = 0110
    set_b(1, 1, 0, 1, 4'b0110);
    tick;
    check("wb1_wf", dob_wf, 4'b0110);
    check("wb1_rf", dob_rf, 4'b0000);
    check("wb1_nc", dob_nc, 4'b1001);
    check("wb1_rg", dob_rg, 4'b1001);

    // Read-write collision: A writes word 2 (bits 5:4), B reads word 1
    set_a(1, 1, 0, 2, 2'b11);
    set_b(1, 0, 0, 1, 0);
    tick;
    check("rw_dob_pre", dob_wf, 4'b0110);
    check("rw_coll", coll_wf, 1);
    check("rw_cnt", cnt_wf, 1);
    check("rw_doa_wf", doa_wf, 2'b11);
    check("rw_doa_rf", doa_rf, 2'b10);
    set_a(0, 0, 0, 0, 0);
    tick;
    check("rw_after", dob_wf, 4'b0111);
    check("rw_coll_off", coll_wf, 0);
    check("rw_cnt_hold", cnt_wf, 1);

    // Write-write collision: B data wins on overlapping bits
    set_a(1, 1, 0, 2, 2'b11);
    set_b(1, 1, 0, 1, 4'b0000);
    tick;
    check("ww_coll", coll_wf, 1);
    check("ww_cnt", cnt_wf, 2);
    check("ww_dob_wf", dob_wf, 4'b0000);
    set_a(0, 0, 0, 0, 0);
    set_b(1, 0, 0, 1, 0);
    tick;
    check("ww_after", dob_wf, 4'b0000);

    // A reads word 3 (bits 7:6) while B overwrites word 1
    set_a(1, 0, 0, 3, 0);
    set_b(1, 1, 0, 1, 4'b1101);
    tick;
    check("wr_doa_pre", doa_wf, 2'b00);
    check("wr_cnt", cnt_wf, 3);
    set_b(0, 0, 0, 0, 0);
    tick;
    check("wr_doa_after", doa_wf, 2'b11);
    check("wr_coll_off", coll_wf, 0);

    // Port-B write modes: F over stored 3, previous output 1001
    set_a(0, 0, 0, 0, 0);
    set_b(1, 1, 0, 5, 4'h3);
    tick;
    set_b(1, 0, 0, 0, 0);
    tick;
    check("pre_nc", dob_nc, 4'b1001);
    set_b(1, 1, 0, 5, 4'hF);
    tick;
    check("mode_wf", dob_wf, 4'hF);
    check("mode_rf", dob_rf, 4'h3);
    check("mode_nc", dob_nc, 4'b1001);
    set_b(1, 0, 0, 5, 0);
    tick;
    check("mode_rd5", dob_wf, 4'hF);

    // SSR and two-edge latency on the registered port
    set_b(1, 1, 0, 6, 4'h5);
    tick;
    set_b(1, 0, 1, 0, 0);
    tick;
    check("ssr_rg", dob_rg, 4'hA);
    check("ssr_wf", dob_wf, 4'hA);
    set_b(1, 0, 0, 6, 0);
    tick;
    check("lat_rg_1", dob_rg, 4'b1001);
    check("rd6_wf", dob_wf, 4'h5);
    tick;
    check("lat_rg_2", dob_rg, 4'h5);
    set_b(0, 0, 0, 0, 0);
    tick;
    check("enb0_hold", dob_rg, 4'h5);
    set_b(1, 0, 0, 0, 0);
    tick;
    check("enb0_stage", dob_rg, 4'h5);
    tick;
    check("rd0_rg", dob_rg, 4'b1001);

    // Counter saturation
    set_a(1, 1, 0, 20, 2'b00);
    set_b(1, 0, 0, 10, 0);
    for (int i = 0; i < 300; i++) tick;
    check("sat_cnt", cnt_wf, 255);
    check("sat_coll", coll_wf, 1);
    check("sat_cnt_rg", cnt_rg, 255);
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    tick;
    check("sat_hold", cnt_wf, 255);
    check("sat_coll_off", coll_wf, 0);

    // Reset with data in flight and a colliding write request
    set_b(1, 0, 0, 6, 0);
    tick;
    rst = 1'b1;
    set_a(1, 1, 0, 0, 2'b11);
    set_b(1, 0, 0, 0, 0);
    tick;
    check("rst2_doa", doa_wf, 2'b10);
    check("rst2_dob", dob_wf, 4'hC);
    check("rst2_coll", coll_wf, 0);
    check("rst2_cnt", cnt_wf, 0);
    check("rst2_dob_rg", dob_rg, 4'hC);
    rst = 1'b0;
    set_a(0, 0, 0, 0, 0);
    tick;
    check("rst2_array", dob_wf, 4'b1001);
    check("rst2_flush_rg", dob_rg, 4'hC);
    check("rst2_coll_off", coll_wf, 0);
    set_a(1, 0, 1, 0, 0);
    tick;
    check("post_rg", dob_rg, 4'b1001);
    check("ssra_wf", doa_wf, 2'b01);
    check("ssra_rg", doa_rg, 2'b01);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/x_ramb_dp_param.md
X_RAMB_DP_PARAM -- requirements
Module: X_RAMB_DP_PARAM

Interface
REQ-001 SHALL have parameter MEM_BITS, default 16384, total array bits; power of two, 1024..65536.
REQ-002 SHALL have parameters WIDTH_A, WIDTH_B, default 2 and 4, port data widths; each one of 1,2,4,8,16,32.
REQ-003 SHALL have parameters WRITE_MODE_A, WRITE_MODE_B, default "WRITE_FIRST", one of WRITE_FIRST, READ_FIRST, NO_CHANGE.
REQ-004 SHALL have parameters INIT_A/INIT_B and SRVAL_A/SRVAL_B, default 0, output values after RST and after SSR.
REQ-005 SHALL have parameters DOA_REG, DOB_REG, default 0, 1 = extra output pipeline register.
REQ-006 SHALL derive AW_A = log2(MEM_BITS/WIDTH_A) and AW_B = log2(MEM_BITS/WIDTH_B).
REQ-007 CLK  input  1  single clock for both ports, rising edge.
REQ-008 RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-009 ENA, WEA, SSRA  input  1 each  port A enable, write enable, output set/reset.
REQ-010 ADDRA  input  AW_A  port A word address; DIA  input  WIDTH_A  write data.
REQ-011 DOA  output  WIDTH_A  port A registered read data.
REQ-012 ENB, WEB, SSRB, ADDRB (AW_B), DIB (WIDTH_B), DOB (WIDTH_B): port B equivalents.
REQ-013 COLL  output  1  registered one-cycle collision pulse.
REQ-014 COLL_CNT  output  8  saturating collision counter.

Function
REQ-015 Port A word at ADDRA SHALL occupy array bits ADDRA*WIDTH_A .. ADDRA*WIDTH_A+WIDTH_A-1, bit 0 of DIA/DOA at lowest index; same rule for port B.
REQ-016 Array SHALL be all zero at time zero and SHALL NOT be altered by RST.
REQ-017 Write: edge with EN=1, WE=1, RST=0 SHALL store DI at the addressed word.
REQ-018 Read stage SHALL update only when EN=1: SSR=1 -> SRVAL; else WE=0 -> stored word; WE=1 -> DI (WRITE_FIRST), old word (READ_FIRST), hold (NO_CHANGE).
REQ-019 DO_REG=0: read stage drives DO; latency 1 edge.
REQ-020 DO_REG=1: stage 1 captures per REQ-018 ignoring SSR; output register loads SSR ? SRVAL : stage 1 when EN=1; latency 2 edges; EN=0 freezes both stages.
REQ-021 Collision: both EN=1, bit ranges overlap, at least one WE=1.
REQ-022 Write-write collision: overlapping bits SHALL take port B data; non-overlapping bits of each word written normally.
REQ-023 Read-write collision: reading port SHALL return pre-write array contents for all its bits.
REQ-024 Collision with WRITE_FIRST writer: writer's own DO SHALL follow REQ-018 unchanged.
REQ-025 COLL SHALL be 1 on the edge after a collision cycle, else 0.
REQ-026 COLL_CNT SHALL increment per collision cycle, saturate at 255, never wrap.
REQ-027 Port ranges outside array impossible by construction; no out-of-range handling required.

Reset
REQ-028 RST=1 at an edge SHALL set DOA=INIT_A, DOB=INIT_B, both stage-1 registers to INIT, COLL=0, COLL_CNT=0.
REQ-029 RST SHALL have priority over EN, SSR, WE: no write occurs in an RST cycle, no collision counted.
REQ-030 RST asserted mid-pipeline (DO_REG=1) SHALL discard in-flight read data; first valid read returns 2 edges after RST deassert.

Verification (MEM_BITS=16384, WIDTH_A=2, WIDTH_B=4)
REQ-031 Write A addr 0 DIA=2'b01, addr 1 DIA=2'b10; read B addr 0 -> DOB=4'b1001 one edge later (DOB_REG=0).
REQ-032 Array addr B1=4'b0110; A writes addr 2 DIA=2'b11 while B reads addr 1 -> DOB=4'b0110, COLL=1 next edge, COLL_CNT=1; later B read addr 1 -> 4'b0111.
REQ-033 Same cycle A writes addr 2 DIA=2'b11, B writes addr 1 DIB=4'b0000 -> B read addr 1 returns 4'b0000; COLL_CNT increments.
REQ-034 DOB_REG=1, SSRB=1 with SRVAL_B=4'hA: DOB=4'hA after 1 edge; normal read of 4'h5 appears 2 edges after request.
REQ-035 300 consecutive collision cycles -> COLL_CNT=255 and holds; RST -> COLL_CNT=0, DOA=INIT_A, DOB=INIT_B, array unchanged.
REQ-036 Each WRITE_MODE with WE=1, DI=4'hF over stored 4'h3 -> DOB = 4'hF / 4'h3 / previous DOB.
